shadow_save_sequencer: RTL and testbench



---
 rtl/ariane_pkg.sv | 16 +
 rtl/shadow_save_hazard.sv | 31 +++
 rtl/shadow_save_sequencer.sv | 122 ++++++++++++
 tb/tb_shadow_save_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared types and sizing helpers for the shadow-register save sequencer.
package ariane_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STORE = 1'b1
  } shadow_save_state_e;

  // Frame size in bytes: NrRegs GPRs plus mepc and mcause, rounded up to 16-byte stack alignment.
  function automatic int unsigned frame_bytes(input int unsigned xlen, input int unsigned nr_regs);
    int unsigned raw;
    raw = (nr_regs + 2) * xlen / 8;
    return ((raw + 15) / 16) * 16;
  endfunction

endpackage

// File: rtl/shadow_save_hazard.sv
// Page-offset hazard: flags a load whose offset hits any frame word from the current index up.
// Compiled only when SHADOW_SAVE_HAZARD_EN is defined; otherwise the top stalls on busy.
`ifdef SHADOW_SAVE_HAZARD_EN
module shadow_save_hazard #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NrWords = 18
) (
  input  logic [11:0] base_i,
  input  logic [4:0]  level_i,
  input  logic [11:0] page_offset_i,
  output logic        match_o
);

  localparam int unsigned W = (XLEN == 64) ? 3 : 2;

  logic [11:0] word_off;

  // Only bits [11:W] take part; the XOR-shift drops the sub-word byte offset.
  always_comb begin
    match_o  = 1'b0;
    word_off = '0;
    for (int j = 0; j < NrWords; j++) begin
      word_off = base_i + 12'(j * (XLEN / 8));
      if ((5'(j) >= level_i) && (((word_off ^ page_offset_i) >> W) == 12'd0)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/shadow_save_sequencer.sv
// Spills mepc, mcause and a GPR snapshot into a freshly allocated stack frame, one word per store handshake.
// Define SHADOW_SAVE_HAZARD_EN for the exact page-offset comparator; otherwise the hazard flag equals busy_o.
module shadow_save_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NrRegs = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     save_i,
  input  logic [XLEN-1:0]          sp_i,
  input  logic [XLEN-1:0]          mepc_i,
  input  logic [XLEN-1:0]          mcause_i,
  input  logic [NrRegs*XLEN-1:0]   regs_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [XLEN-1:0]          next_sp_o,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [XLEN-1:0]          req_addr_o,
  output logic [XLEN-1:0]          req_data_o,
  output logic [4:0]               save_level_o,
  input  logic [4:0]               raddr_i,
  output logic [XLEN-1:0]          rdata_o,
  input  logic [11:0]              page_offset_i,
  output logic                     page_offset_match_o,
  output shadow_save_state_e       dbg_state_o
);

  localparam int unsigned     NrWords    = NrRegs + 2;
  localparam logic [XLEN-1:0] FrameBytes = XLEN'(frame_bytes(XLEN, NrRegs));
  localparam logic [XLEN-1:0] WordBytes  = XLEN'(XLEN / 8);
  localparam logic [4:0]      LastIdx    = 5'(NrWords - 1);

  shadow_save_state_e state;
  logic [XLEN-1:0]    buffer [NrWords];
  logic [4:0]         next_level;

  assign next_level  = save_level_o + 5'd1;
  assign dbg_state_o = state;

  // Store handshake: a word transfers on a clock edge where req_valid_o && req_ready_i;
  // until then req_valid_o stays high and req_addr_o/req_data_o hold their values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ready_o      <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      req_valid_o  <= 1'b0;
      req_addr_o   <= '0;
      req_data_o   <= '0;
      save_level_o <= '0;
      next_sp_o    <= '0;
      for (int k = 0; k < NrWords; k++) buffer[k] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (save_i) begin
            buffer[0] <= mepc_i;
            buffer[1] <= mcause_i;
            for (int k = 0; k < NrRegs; k++) buffer[k+2] <= regs_i[k*XLEN +: XLEN];
            next_sp_o    <= sp_i - FrameBytes;
            req_addr_o   <= sp_i - FrameBytes;
            req_data_o   <= mepc_i;
            save_level_o <= '0;
            req_valid_o  <= 1'b1;
            ready_o      <= 1'b0;
            busy_o       <= 1'b1;
            state        <= STORE;
          end
        end
        STORE: begin
          if (req_ready_i) begin
            if (save_level_o == LastIdx) begin
              req_valid_o <= 1'b0;
              ready_o     <= 1'b1;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              state       <= IDLE;
            end else begin
              save_level_o <= next_level;
              req_addr_o   <= req_addr_o + WordBytes;
              req_data_o   <= buffer[next_level];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    if ({1'b0, raddr_i} < 6'(NrWords)) rdata_o = buffer[raddr_i];
  end

`ifdef SHADOW_SAVE_HAZARD_EN
  logic hazard_hit;

  shadow_save_hazard #(
    .XLEN    (XLEN),
    .NrWords (NrWords)
  ) u_hazard (
    .base_i        (next_sp_o[11:0]),
    .level_i       (save_level_o),
    .page_offset_i (page_offset_i),
    .match_o       (hazard_hit)
  );

  assign page_offset_match_o = busy_o & hazard_hit;
`else
  logic unused_page_offset;
  assign unused_page_offset  = ^page_offset_i;
  // Without the comparator, any load during a save is treated as a hazard.
  assign page_offset_match_o = busy_o;
`endif

endmodule

// File: tb/tb_shadow_save_sequencer.sv
// Directed bench for shadow_save_sequencer (XLEN=64, NrRegs=16): frame contents, addressing, stalls, hazard, reset.
module tb_shadow_save_sequencer;
  import ariane_pkg::*;

  logic                clk;
  logic                rst_i;
  logic                save_i;
  logic [63:0]         sp_i;
  logic [63:0]         mepc_i;
  logic [63:0]         mcause_i;
  logic [16*64-1:0]    regs_i;
  logic                ready_o;
  logic                busy_o;
  logic                done_o;
  logic [63:0]         next_sp_o;
  logic                req_valid_o;
  logic                req_ready_i;
  logic [63:0]         req_addr_o;
  logic [63:0]         req_data_o;
  logic [4:0]          save_level_o;
  logic [4:0]          raddr_i;
  logic [63:0]         rdata_o;
  logic [11:0]         page_offset_i;
  logic                page_offset_match_o;
  shadow_save_state_e  dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int hz_mode     = 0;

  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];

  shadow_save_sequencer #(.XLEN(64), .NrRegs(16)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .save_i              (save_i),
    .sp_i                (sp_i),
    .mepc_i              (mepc_i),
    .mcause_i            (mcause_i),
    .regs_i              (regs_i),
    .ready_o             (ready_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .next_sp_o           (next_sp_o),
    .req_valid_o         (req_valid_o),
    .req_ready_i         (req_ready_i),
    .req_addr_o          (req_addr_o),
    .req_data_o          (req_data_o),
    .save_level_o        (save_level_o),
    .raddr_i             (raddr_i),
    .rdata_o             (rdata_o),
    .page_offset_i       (page_offset_i),
    .page_offset_match_o (page_offset_match_o),
    .dbg_state_o         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived hazard expectation while a word is offered (frame base 0x...0F70).
  function automatic logic exp_match(input int mode, input logic [4:0] lvl);
`ifdef SHADOW_SAVE_HAZARD_EN
    if (mode == 1) return (lvl <= 5'd2);
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // scoreboard: handshakes, stall stability, hazard flag
  logic        stalled = 1'b0;
  logic [63:0] st_addr, st_data;

  always @(negedge clk) begin
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {63'b0, req_valid_o}, 64'd1);
        check("stall_addr", req_addr_o, st_addr);
        check("stall_data", req_data_o, st_data);
      end
      if (req_valid_o && hz_mode != 0)
        check("hazard", {63'b0, page_offset_match_o}, {63'b0, exp_match(hz_mode, save_level_o)});
      if (req_valid_o && req_ready_i) begin
        if (exp_addr_q.size() == 0) begin
          check("st_extra", 64'd1, 64'd0);
        end else begin
          check("st_level", {59'b0, save_level_o}, 64'(18 - exp_addr_q.size()));
          check("st_addr", req_addr_o, exp_addr_q.pop_front());
          check("st_data", req_data_o, exp_data_q.pop_front());
        end
      end
      stalled = req_valid_o && !req_ready_i;
      st_addr = req_addr_o;
      st_data = req_data_o;
    end
  end

  // driver tasks
  task automatic start_save(input logic [63:0] sp, input logic [63:0] mepc, input logic [63:0] mcause,
                            input logic [63:0] rbase, input logic [63:0] exp_base);
    for (int w = 0; w < 18; w++) begin
      exp_addr_q.push_back(exp_base + 64'(w * 8));
      exp_data_q.push_back(w == 0 ? mepc : (w == 1 ? mcause : rbase + 64'(w - 2)));
    end
    @(posedge clk); #1;
    sp_i     = sp;
    mepc_i   = mepc;
    mcause_i = mcause;
    for (int k = 0; k < 16; k++) regs_i[k*64 +: 64] = rbase + 64'(k);
    save_i   = 1'b1;
  endtask

  task automatic wait_done(input bit rnd, output int vcycles, output bit ok);
    vcycles = 0;
    ok      = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (rnd) begin
        req_ready_i = 1'($urandom_range(0, 1));
        save_i      = (req_valid_o && save_level_o < 5'd10) ? 1'($urandom_range(0, 1)) : 1'b0;
        sp_i        = 64'h1234_5670;
      end else begin
        save_i = 1'b0;
      end
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      if (req_valid_o) vcycles++;
    end
    save_i      = 1'b0;
    req_ready_i = 1'b1;
  endtask

  task automatic finish_checks(input bit ok, input logic [63:0] exp_sp);
    check("done_seen", {63'b0, ok}, 64'd1);
    check("done_ready", {63'b0, ready_o}, 64'd1);
    check("done_busy", {63'b0, busy_o}, 64'd0);
    check("done_valid", {63'b0, req_valid_o}, 64'd0);
    check("done_match", {63'b0, page_offset_match_o}, 64'd0);
    check("words_left", 64'(exp_addr_q.size()), 64'd0);
    check("next_sp", next_sp_o, exp_sp);
    @(negedge clk);
    check("done_pulse", {63'b0, done_o}, 64'd0);
  endtask

  task automatic check_reset_state();
    check("rst_ready", {63'b0, ready_o}, 64'd1);
    check("rst_busy", {63'b0, busy_o}, 64'd0);
    check("rst_done", {63'b0, done_o}, 64'd0);
    check("rst_valid", {63'b0, req_valid_o}, 64'd0);
    check("rst_addr", req_addr_o, 64'd0);
    check("rst_data", req_data_o, 64'd0);
    check("rst_level", {59'b0, save_level_o}, 64'd0);
    check("rst_next_sp", next_sp_o, 64'd0);
    check("rst_match", {63'b0, page_offset_match_o}, 64'd0);
    check("rst_state", {63'b0, dbg_state}, {63'b0, IDLE});
    for (int a = 0; a < 20; a++) begin
      raddr_i = 5'(a);
      #1;
      check("rst_rdata", rdata_o, 64'd0);
    end
  endtask

  initial begin
    int vc;
    bit ok;
    rst_i = 1'b1; save_i = 1'b0; sp_i = '0; mepc_i = '0; mcause_i = '0; regs_i = '0;
    req_ready_i = 1'b1; raddr_i = '0; page_offset_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Frame 1: full throughput, hazard offset 0xF80 (word 2 at 0x...0F80)
    hz_mode = 1; page_offset_i = 12'hF80;
    start_save(64'h8000_1000, 64'h1111_2222_3333_4444, 64'h8000_0000_0000_000B, 64'hA000, 64'h8000_0F70);
    wait_done(1'b0, vc, ok);
    check("latency", 64'(vc), 64'd18);
    finish_checks(ok, 64'h8000_0F70);
    raddr_i = 5'd0; #1;
    check("rdata_mepc", rdata_o, 64'h1111_2222_3333_4444);

    // Frame 2: wrapping allocation, random back-pressure, save_i noise during STORE
    hz_mode = 0;
    start_save(64'h40, 64'h5555_0000_0000_0001, 64'h2, 64'hD000, 64'hFFFF_FFFF_FFFF_FFB0);
    wait_done(1'b1, vc, ok);
    finish_checks(ok, 64'hFFFF_FFFF_FFFF_FFB0);
    repeat (3) @(negedge clk);
    check("no_restart", {63'b0, busy_o}, 64'd0);

    // Frame 3: hazard offset 0x000 never hits this frame
    hz_mode = 2; page_offset_i = 12'h000;
    start_save(64'h8000_1000, 64'hCAFE_F00D_0000_1234, 64'h7, 64'hB000, 64'h8000_0F70);
    wait_done(1'b0, vc, ok);
    finish_checks(ok, 64'h8000_0F70);
    raddr_i = 5'd1;  #1; check("rdata_mcause", rdata_o, 64'h7);
    raddr_i = 5'd2;  #1; check("rdata_reg0", rdata_o, 64'hB000);
    raddr_i = 5'd17; #1; check("rdata_reg15", rdata_o, 64'hB00F);
    raddr_i = 5'd18; #1; check("rdata_oob18", rdata_o, 64'd0);
    raddr_i = 5'd20; #1; check("rdata_oob20", rdata_o, 64'd0);
    raddr_i = 5'd31; #1; check("rdata_oob31", rdata_o, 64'd0);

    // Frame 4: reset asserted while word 5 is offered
    hz_mode = 0;
    start_save(64'h2000, 64'h9, 64'hA, 64'hE000, 64'h1F70);
    @(posedge clk); #1;
    save_i = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_valid_o && save_level_o == 5'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_idx5", {63'b0, ok}, 64'd1);
    rst_i = 1'b1;
    #1;
    check_reset_state();
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Frame 5: clean run after the abandoned frame
    hz_mode = 1; page_offset_i = 12'hF80;
    start_save(64'h8000_1000, 64'h0BAD_BEEF_0000_0042, 64'hC, 64'hC000, 64'h8000_0F70);
    wait_done(1'b0, vc, ok);
    check("latency2", 64'(vc), 64'd18);
    finish_checks(ok, 64'h8000_0F70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
